// File: rtl/ddr_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_word_receiver
//  Purpose  : Deserialises the rising/falling sample pair from an IDDR into a
//             bit stream, hunts for a sync word at either bit alignment, locks
//             word framing to it and emits parallel words with a valid strobe.
//  Revision : 1.0  initial release
// ============================================================================
module ddr_word_receiver #(
  parameter int                WIDTH        = 8,      // even, >= 4
  parameter logic [WIDTH-1:0]  SYNC_PATTERN = 8'hBC   // MSB is earliest on wire
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ddr_q1,     // rising-edge bit, earlier in time
  input  logic             ddr_q2,     // falling-edge bit, later in time
  input  logic             resync,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             sync_flag,
  output logic             locked,
  output logic [7:0]       sync_cnt
);

  localparam int                HALF      = WIDTH / 2;
  localparam int                PH_W      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int                FILL_W    = $clog2(HALF + 2);
  // Matching needs WIDTH+1 genuine bits in the shift register, i.e. HALF+1 cycles.
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(HALF + 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(HALF - 1);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     sr_q, sr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic               offset_q, offset_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               sync_flag_q, sync_flag_d;
  logic [7:0]         sync_cnt_q, sync_cnt_d;

  logic [WIDTH-1:0]   win0, win1, word;
  logic               hit0, hit1, emit;

  // Next-state logic: shifting, fill tracking, hunt/lock control and word output.
  always_comb begin
    sr_d        = {sr_q[WIDTH-2:0], ddr_q1, ddr_q2};
    fill_d      = (fill_q == FILL_DONE) ? fill_q : fill_q + FILL_W'(1);
    win0        = sr_q[WIDTH-1:0];
    win1        = sr_q[WIDTH:1];
    hit0        = (win0 == SYNC_PATTERN);
    hit1        = (win1 == SYNC_PATTERN);
    state_d     = state_q;
    offset_d    = offset_q;
    phase_d     = phase_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    sync_flag_d = 1'b0;
    sync_cnt_d  = sync_cnt_q;
    emit        = 1'b0;
    word        = offset_q ? win1 : win0;

    if (resync) begin
      // Resync always wins, even over a simultaneous hunt match.
      state_d    = ST_HUNT;
      sync_cnt_d = 8'd0;
    end else if (state_q == ST_HUNT) begin
      if ((fill_q == FILL_DONE) && (hit0 || hit1)) begin
        state_d  = ST_LOCKED;
        offset_d = ~hit0;              // even alignment preferred on a tie
        phase_d  = PH_W'(1);           // detection cycle counts as phase 0
        word     = hit0 ? win0 : win1;
        emit     = 1'b1;
      end
    end else begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      emit    = (phase_q == '0);
    end

    if (emit) begin
      data_d      = word;
      valid_d     = 1'b1;
      sync_flag_d = (word == SYNC_PATTERN);
      if (sync_flag_d && (sync_cnt_q != 8'hFF)) begin
        sync_cnt_d = sync_cnt_q + 8'd1;
      end
    end
  end

  // State and output registers; asynchronous reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      sr_q        <= '0;
      fill_q      <= '0;
      phase_q     <= '0;
      offset_q    <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sync_flag_q <= 1'b0;
      sync_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      phase_q     <= phase_d;
      offset_q    <= offset_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sync_flag_q <= sync_flag_d;
      sync_cnt_q  <= sync_cnt_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign sync_flag = sync_flag_q;
  assign locked    = (state_q == ST_LOCKED);
  assign sync_cnt  = sync_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_word_receiver
//  Purpose  : Self-checking bench for ddr_word_receiver with a bit-stream
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ddr_word_receiver;

  localparam int         W  = 8;
  localparam logic [7:0] SP = 8'hBC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ddr_q1, ddr_q2, resync;
  logic [7:0] data, ff_data;
  logic       valid, sync_flag, locked;
  logic       ff_valid, ff_sync_flag, ff_locked;
  logic [7:0] sync_cnt, ff_sync_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr_word_receiver #(.WIDTH(8), .SYNC_PATTERN(8'hBC)) u_dut (
    .clk(clk), .rst_n(rst_n), .ddr_q1(ddr_q1), .ddr_q2(ddr_q2), .resync(resync),
    .data(data), .valid(valid), .sync_flag(sync_flag), .locked(locked),
    .sync_cnt(sync_cnt)
  );

  // Second instance only used for the all-ones fill test.
  ddr_word_receiver #(.WIDTH(8), .SYNC_PATTERN(8'hFF)) u_ff (
    .clk(clk), .rst_n(rst_n), .ddr_q1(ddr_q1), .ddr_q2(ddr_q2), .resync(resync),
    .data(ff_data), .valid(ff_valid), .sync_flag(ff_sync_flag), .locked(ff_locked),
    .sync_cnt(ff_sync_cnt)
  );

  // ---------------- reference model ----------------
  logic       hist[$];      // received bits, newest at the back
  int         ncyc;         // clock edges since reset release
  logic       m_locked;
  logic       m_off;
  int         m_tlock;
  logic [7:0] e_data, e_cnt;
  logic       e_valid, e_sflag, e_locked;

  function automatic logic [7:0] win(input int off);
    logic [7:0] w;
    int n;
    n = hist.size();
    w = '0;
    if (n >= W + 1) begin
      for (int i = 0; i < W; i++) w[W-1-i] = hist[n-W-off+i];
    end
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    ncyc     = 0;
    m_locked = 1'b0;
    m_off    = 1'b0;
    m_tlock  = 0;
    e_data   = '0;
    e_cnt    = '0;
    e_valid  = 1'b0;
    e_sflag  = 1'b0;
    e_locked = 1'b0;
  endtask

  // One clock edge: decide from the bits received so far, then take in the new pair.
  task automatic model_edge(input logic q1, input logic q2, input logic rs);
    logic       emit;
    logic [7:0] w;
    e_valid = 1'b0;
    e_sflag = 1'b0;
    emit    = 1'b0;
    if (rs) begin
      m_locked = 1'b0;
      e_cnt    = '0;
    end else if (!m_locked) begin
      if (ncyc >= W/2 + 1) begin
        if (win(0) == SP) begin
          m_locked = 1'b1; m_off = 1'b0; m_tlock = ncyc;
        end else if (win(1) == SP) begin
          m_locked = 1'b1; m_off = 1'b1; m_tlock = ncyc;
        end
      end
      emit = m_locked;
    end else begin
      emit = (((ncyc - m_tlock) % (W/2)) == 0);
    end
    if (emit) begin
      w       = win(m_off ? 1 : 0);
      e_data  = w;
      e_valid = 1'b1;
      e_sflag = (w == SP);
      if (e_sflag && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
    end
    e_locked = m_locked;
    hist.push_back(q1);
    hist.push_back(q2);
    while (hist.size() > 32) void'(hist.pop_front());
    ncyc++;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("valid", {31'd0, valid}, {31'd0, e_valid});
    check("data", {24'd0, data}, {24'd0, e_data});
    check("sync_flag", {31'd0, sync_flag}, {31'd0, e_sflag});
    check("locked", {31'd0, locked}, {31'd0, e_locked});
    check("sync_cnt", {24'd0, sync_cnt}, {24'd0, e_cnt});
  end

  // ---------------- stimulus ----------------
  logic bq[$];

  function automatic logic pop_bit();
    if (bq.size() == 0) return 1'b0;
    return bq.pop_front();
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bq.push_back(b[i]);
  endtask

  task automatic cycle(input logic q1, input logic q2, input logic rs);
    ddr_q1 = q1;
    ddr_q2 = q2;
    resync = rs;
    @(posedge clk);
    #1;
    if (rst_n) model_edge(q1, q2, rs);
    else model_reset();
  endtask

  task automatic run_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      logic a, b;
      a = pop_bit();
      b = pop_bit();
      cycle(a, b, 1'b0);
    end
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      logic a, b, rs;
      if (bq.size() < 2) begin
        push_byte(8'($urandom));
        if ($urandom_range(0, 3) == 0) push_byte(SP);
        if ($urandom_range(0, 1) == 0) bq.push_back(1'($urandom));
      end
      a  = pop_bit();
      b  = pop_bit();
      rs = ($urandom_range(0, 39) == 0);
      cycle(a, b, rs);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ddr_q1 = 1'b1;
    ddr_q2 = 1'b1;
    resync = 1'b0;
    model_reset();
    #1;
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_locked", {31'd0, locked}, 32'd0);
    check("reset_cnt", {24'd0, sync_cnt}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;

    // Fill: all-ones stream, 8'hFF pattern must not lock before edge 6.
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      check("fill_no_lock", {31'd0, ff_locked}, 32'd0);
    end
    cycle(1'b1, 1'b1, 1'b0);
    check("fill_lock", {31'd0, ff_locked}, 32'd1);
    check("fill_valid", {31'd0, ff_valid}, 32'd1);
    check("fill_data", {24'd0, ff_data}, 32'hFF);
    check("fill_flag", {31'd0, ff_sync_flag}, 32'd1);

    // Even alignment.
    push_byte(8'h00); push_byte(SP); push_byte(8'h12); push_byte(8'h34);
    run_pairs(8);
    check("even_hunt", {31'd0, locked}, 32'd0);
    run_pairs(1);
    check("even_valid", {31'd0, valid}, 32'd1);
    check("even_data", {24'd0, data}, 32'hBC);
    check("even_flag", {31'd0, sync_flag}, 32'd1);
    check("even_locked", {31'd0, locked}, 32'd1);
    check("model_even_data", {24'd0, e_data}, 32'hBC);
    run_pairs(3);
    run_pairs(1);
    check("even_w1", {24'd0, data}, 32'h12);
    check("even_w1_valid", {31'd0, valid}, 32'd1);
    run_pairs(3);
    run_pairs(1);
    check("even_w2", {24'd0, data}, 32'h34);
    check("even_cnt", {24'd0, sync_cnt}, 32'd1);
    check("model_even_w2", {24'd0, e_data}, 32'h34);
    run_pairs(1);

    // Resync mid-word, then garbage, then sync at odd alignment.
    bq.delete();
    cycle(1'b0, 1'b0, 1'b1);
    check("resync_locked", {31'd0, locked}, 32'd0);
    check("resync_valid", {31'd0, valid}, 32'd0);
    check("resync_cnt", {24'd0, sync_cnt}, 32'd0);
    check("resync_hold", {24'd0, data}, 32'h34);
    push_byte(8'h0F);
    bq.push_back(1'b0);
    push_byte(SP); push_byte(8'h12); push_byte(8'h34);
    run_pairs(9);
    check("odd_hunt", {31'd0, locked}, 32'd0);
    check("odd_hold", {24'd0, data}, 32'h34);
    run_pairs(1);
    check("odd_valid", {31'd0, valid}, 32'd1);
    check("odd_data", {24'd0, data}, 32'hBC);
    check("odd_locked", {31'd0, locked}, 32'd1);
    check("model_odd_off", {31'd0, m_off}, 32'd1);
    run_pairs(4);
    check("odd_w1", {24'd0, data}, 32'h12);
    run_pairs(4);
    check("odd_w2", {24'd0, data}, 32'h34);

    // Repeated sync words: counter saturates.
    bq.delete();
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 302; i++) push_byte(SP);
    run_pairs(302 * 4);
    check("sat_cnt", {24'd0, sync_cnt}, 32'd255);
    check("model_sat_cnt", {24'd0, e_cnt}, 32'd255);

    // Randomized traffic with embedded sync words and resync pulses.
    bq.delete();
    run_rand(1500);

    // Async reset between two strobes.
    bq.delete();
    run_pairs(6);
    cycle(1'b0, 1'b0, 1'b1);
    push_byte(SP); push_byte(8'hA5); push_byte(8'h5A);
    run_pairs(5);
    check("pre_reset_valid", {31'd0, valid}, 32'd1);
    check("pre_reset_data", {24'd0, data}, 32'hBC);
    run_pairs(2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", {31'd0, valid}, 32'd0);
    check("arst_data", {24'd0, data}, 32'd0);
    check("arst_flag", {31'd0, sync_flag}, 32'd0);
    check("arst_locked", {31'd0, locked}, 32'd0);
    check("arst_cnt", {24'd0, sync_cnt}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    bq.delete();
    run_pairs(10);
    check("post_reset_locked", {31'd0, locked}, 32'd0);
    check("post_reset_data", {24'd0, data}, 32'd0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr_word_receiver.md
# ddr_word_receiver

Input-side counterpart of the DDR output register. Accepts the two per-cycle samples of a same-edge-pipelined input DDR capture: Q1 is the rising-edge bit and Q2 the following falling-edge bit. It shifts them into a bit stream, hunts for a sync word at either bit alignment and locks word framing to it. It then emits parallel words with a valid strobe. It sits between the IDDR pin primitive and the FIFO/TLU-style consumers in the readout path.

## Interface
- WIDTH, 8, word width in bits; must be even and ≥ 4.
- SYNC_PATTERN, 8'hBC, WIDTH-bit framing word; MSB is the earliest bit on the wire.
- CLK  input  1  capture clock; the IDDR and all logic use this clock.
- RST_N  input  1  reset. One clock; reset is asynchronous and active-low.
- DDR_Q1  input  1  bit sampled on the rising edge; earlier in time.
- DDR_Q2  input  1  bit sampled on the falling edge; later in time.
- RESYNC  input  1  single-cycle pulse; drop lock and re-enter HUNT.
- DATA  output  WIDTH  received word, MSB first; held between strobes.
- VALID  output  1  one-cycle strobe; DATA is new.
- SYNC_FLAG  output  1  qualifies VALID; the current DATA equals SYNC_PATTERN.
- LOCKED  output  1  framing is established.
- SYNC_CNT  output  8  number of sync words received while locked; saturates at 255.

## Operation
- Reset values: all outputs are 0. The shift register, fill counter and phase counter are 0. State is HUNT.
- Shift register SR holds WIDTH+1 bits. Every cycle SR <= {SR[WIDTH-2:0], DDR_Q1, DDR_Q2}, so bit 0 is the newest bit.
- Fill counter: matching is inhibited until WIDTH/2+1 cycles after reset release. It does not re-arm on RESYNC.
- Candidate windows: W0 = SR[WIDTH-1:0] and W1 = SR[WIDTH:1].
- State HUNT:
  - If W0 == SYNC_PATTERN, set offset = 0 and go to LOCKED.
  - Else if W1 == SYNC_PATTERN, set offset = 1 and go to LOCKED.
  - If both windows match, W0 wins.
  - No VALID is issued while in HUNT.
- Transition into LOCKED (detection in cycle T):
  - At T+1: DATA = SYNC_PATTERN, VALID = 1, SYNC_FLAG = 1, LOCKED = 1, SYNC_CNT increments.
  - The phase counter (0..WIDTH/2-1) is restarted at T.
- State LOCKED:
  - Every WIDTH/2 cycles, the window selected by offset is registered to DATA with VALID = 1.
  - SYNC_FLAG = 1 when that word equals SYNC_PATTERN.
  - SYNC_CNT increments on each sync word and saturates at 255.
  - Offset and phase never change while locked.
- RESYNC pulse in any state, observed in cycle R:
  - At R+1: LOCKED = 0, VALID = 0, state is HUNT.
  - DATA holds its last value; SYNC_CNT is cleared.
  - HUNT may re-lock from cycle R+1 onward.
- RESYNC in the same cycle as a HUNT match: RESYNC wins and no lock occurs.
- An asynchronous reset mid-word discards the partial word; no VALID is issued.

## Timing
- Latency: the last bit of a word appears on DDR_Q2 (or DDR_Q1 for offset 1) at the IDDR output in cycle N. VALID/DATA are registered in cycle N+1.
- VALID period in LOCKED is exactly WIDTH/2 cycles. VALID is never asserted on two consecutive cycles unless WIDTH = 2 (disallowed).
- All outputs are registered; there are no combinational input-to-output paths.
- SYNC_FLAG and SYNC_CNT update in the same cycle as the corresponding VALID.

## Test plan
- Reset/fill:
  - Stimulus: hold RST_N low, drive Q1 = Q2 = 1, release; SYNC_PATTERN = 8'hFF.
  - Required: no lock before the 5th cycle after release; lock with offset 0 is then detected.
  - Required: the first VALID occurs with DATA = 8'hFF and SYNC_FLAG = 1.
- Even alignment:
  - Stimulus: stream 8'hBC, then 8'h12 and 8'h34, starting on a Q1 bit.
  - Required: VALID at T+1 with DATA = BC, SYNC_FLAG = 1, LOCKED = 1.
  - Required: then DATA = 12 at T+5 and DATA = 34 at T+9; SYNC_CNT = 1.
- Odd alignment:
  - Stimulus: the same stream shifted by one bit, so the sync word starts on a Q2 bit.
  - Required: lock with offset 1; DATA sequence BC, 12, 34 at 4-cycle spacing.
- Repeated sync:
  - Stimulus: 300 consecutive 8'hBC words after lock.
  - Required: SYNC_FLAG = 1 on every VALID; SYNC_CNT saturates at 255 and never wraps.
- RESYNC:
  - Stimulus: pulse RESYNC mid-word while locked, then stream garbage, then 8'hBC at a different alignment.
  - Required: LOCKED = 0 the next cycle; no VALID during garbage; SYNC_CNT = 0.
  - Required: re-lock at the new alignment; DATA holds its old value until the new sync strobe.
- Async reset mid-operation:
  - Stimulus: assert RST_N low between two VALID strobes.
  - Required: all outputs go to 0 immediately, without a clock edge; the partial word is never emitted.
